map_ram_arbiter: RTL

Single-port arbiter for the tile-map RAM, which holds one byte per maze cell: tile index [5:0] and item code [1:0]. It is shared between the VGA render path and game logic. The render path issues one read per pixel-clock and has strict priority. Game-logic reads and writes (dot/energizer consumption, collision queries) are buffered in a small FIFO and issued in free slots, with a programmable anti-starvation override.

---
 rtl/map_ram_arbiter_pkg.sv | 28 ++
 rtl/map_req_fifo.sv | 63 ++++++
 rtl/map_ram_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/map_ram_arbiter_pkg.sv
// Shared constants and types for the tile-map RAM arbiter.
package map_ram_arbiter_pkg;

  localparam int MAP_COLS       = 28;
  localparam int MAP_ROWS       = 36;
  localparam int MAP_AW_DEFAULT = 10;

  // Item code held in bits [7:6] of each map byte.
  localparam logic [1:0] I_NONE      = 2'd0;
  localparam logic [1:0] I_DOT       = 2'd1;
  localparam logic [1:0] I_ENERGIZER = 2'd2;
  localparam logic [1:0] I_WALL      = 2'd3;

  // Owner of the RAM port for one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RENDER = 2'd1,
    GAME   = 2'd2,
    FORCE  = 2'd3
  } slot_e;

  // Tag that travels with each issued read until its data comes back.
  typedef struct packed {
    logic render;
    logic game_rd;
  } tag_t;

endpackage

// File: rtl/map_req_fifo.sv
// Small synchronous FIFO for buffered game-logic RAM requests.
module map_req_fifo
  import map_ram_arbiter_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign o_full  = (level_q == (PW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_rdata = mem_q[rd_ptr_q];
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      level_d = level_q + (PW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (PW+1)'(1);
  end

  // Control state; flushed by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/map_ram_arbiter.sv
// Tile-map RAM arbiter: render reads have priority, game requests fill
// free slots from a FIFO, with an optional anti-starvation forced slot.
module map_ram_arbiter
  import map_ram_arbiter_pkg::*;
#(
  parameter int MAP_AW     = MAP_AW_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_rd_en,
  input  logic [MAP_AW-1:0]             i_rd_addr,
  output logic                          o_rd_valid,
  output logic [7:0]                    o_rd_data,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_we,
  input  logic [MAP_AW-1:0]             i_req_addr,
  input  logic [7:0]                    i_req_wdata,
  output logic                          o_rsp_valid,
  output logic [7:0]                    o_rsp_data,
  output logic [MAP_AW-1:0]             o_ram_addr,
  output logic                          o_ram_we,
  output logic [7:0]                    o_ram_wdata,
  input  logic [7:0]                    i_ram_q,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [15:0]                   o_drop_count
);

  localparam int FW     = 1 + MAP_AW + 8;
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [FW-1:0]       head;
  logic                fifo_full, fifo_empty, push, pop;
  slot_e               slot;
  logic                head_we;
  logic [MAP_AW-1:0]   head_addr;
  logic [7:0]          head_wdata;

  logic [MAP_AW-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  tag_t                tag_p0_q, tag_p0_d, tag_p1_q, tag_p1_d;
  logic                rd_valid_q, rd_valid_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]          rd_data_q, rd_data_d, rsp_data_q, rsp_data_d;
  logic [15:0]         drop_q, drop_d;

  // Ready depends only on registered occupancy, so a pop never frees a slot early.
  assign o_req_ready = !fifo_full;
  assign push        = i_req_valid && o_req_ready;
  assign head_we     = head[FW-1];
  assign head_addr   = head[FW-2 -: MAP_AW];
  assign head_wdata  = head[7:0];

  map_req_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_pop   (pop),
    .i_wdata ({i_req_we, i_req_addr, i_req_wdata}),
    .o_rdata (head),
    .o_level (o_fifo_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Slot owner for this edge: forced game slot, then render, then game.
  always_comb begin
    slot = IDLE;
    if ((MAX_WAIT != 0) && !fifo_empty && (wait_cnt_q == WAIT_W'(MAX_WAIT))) slot = FORCE;
    else if (i_rd_en)                                                       slot = RENDER;
    else if (!fifo_empty)                                                   slot = GAME;
  end

  // RAM port drive, wait counter, drop counter and read-return steering.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag_p0_d    = '0;
    pop         = 1'b0;
    drop_d      = drop_q;
    case (slot)
      RENDER: begin
        ram_addr_d      = i_rd_addr;
        tag_p0_d.render = 1'b1;
      end
      GAME, FORCE: begin
        pop              = 1'b1;
        ram_addr_d       = head_addr;
        ram_we_d         = head_we;
        ram_wdata_d      = head_wdata;
        tag_p0_d.game_rd = !head_we;
        if ((slot == FORCE) && i_rd_en && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      end
      default: ;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (pop || fifo_empty)                        wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_W'(MAX_WAIT))     wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    tag_p1_d    = tag_p0_q;
    rd_valid_d  = tag_p1_q.render;
    rsp_valid_d = tag_p1_q.game_rd;
    rd_data_d   = tag_p1_q.render  ? i_ram_q : rd_data_q;
    rsp_data_d  = tag_p1_q.game_rd ? i_ram_q : rsp_data_q;
  end

  // All registered state; reset clears outputs and discards in-flight tags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wait_cnt_q  <= '0;
      tag_p0_q    <= '0;
      tag_p1_q    <= '0;
      rd_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
      rsp_data_q  <= '0;
      drop_q      <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      tag_p0_q    <= tag_p0_d;
      tag_p1_q    <= tag_p1_d;
      rd_valid_q  <= rd_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rd_data_q   <= rd_data_d;
      rsp_data_q  <= rsp_data_d;
      drop_q      <= drop_d;
    end
  end

  assign o_ram_addr   = ram_addr_q;
  assign o_ram_we     = ram_we_q;
  assign o_ram_wdata  = ram_wdata_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_drop_count = drop_q;

endmodule
